// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory stage: op and state encodings,
// legal SRAM latency range and alignment helpers.
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LD_W  = 3'd0,
      OP_LD_H  = 3'd1,
      OP_LD_HU = 3'd2,
      OP_LD_B  = 3'd3,
      OP_LD_BU = 3'd4,
      OP_ST_W  = 3'd5,
      OP_ST_H  = 3'd6,
      OP_ST_B  = 3'd7
   } lsu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_RESP
   } lsu_state_e;

   localparam int SRAM_LAT_MIN = 1;
   localparam int SRAM_LAT_MAX = 4;

   function automatic logic is_store(lsu_op_e op);
      return (op == OP_ST_W) || (op == OP_ST_H) || (op == OP_ST_B);
   endfunction

   function automatic logic misaligned(lsu_op_e op, logic [1:0] off);
      logic r;
      case (op)
         OP_LD_W, OP_ST_W:           r = (off != 2'b00);
         OP_LD_H, OP_LD_HU, OP_ST_H: r = off[0];
         default:                    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load byte/half
// selection with sign or zero extension. Purely combinational.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_op_e     op_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  we_o,
   output logic [31:0] st_wdata_o,
   output logic [31:0] ld_data_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   // Sub-access-size offset bits are simply not looked at, so unchecked
   // misaligned ops fall onto their naturally aligned container.
   assign byte_w = rdata_i[8*off_i +: 8];
   assign half_w = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      we_o       = 4'b0000;
      st_wdata_o = 32'h0;
      ld_data_o  = 32'h0;
      case (op_i)
         OP_ST_W: begin
            we_o       = 4'b1111;
            st_wdata_o = st_data_i;
         end
         OP_ST_H: begin
            we_o       = 4'b0011 << {off_i[1], 1'b0};
            st_wdata_o = {2{st_data_i[15:0]}};
         end
         OP_ST_B: begin
            we_o       = 4'b0001 << off_i;
            st_wdata_o = {4{st_data_i[7:0]}};
         end
         OP_LD_W:  ld_data_o = rdata_i;
         OP_LD_H:  ld_data_o = {{16{half_w[15]}}, half_w};
         OP_LD_HU: ld_data_o = {16'h0, half_w};
         OP_LD_B:  ld_data_o = {{24{byte_w[7]}}, byte_w};
         OP_LD_BU: ld_data_o = {24'h0, byte_w};
         default:  ld_data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: one op at a time through IDLE/ACCESS/WAIT/RESP.
// Define LSU_ALIGN_CHECK_EN to raise ALE on misaligned word/halfword ops.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int SRAM_LAT = 1,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_dest,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_we,
   output logic [4:0]        resp_dest,
   output logic [31:0]       resp_data,
   output logic              resp_ale,
   output logic              data_sram_en,
   output logic [3:0]        data_sram_we,
   output logic [31:0]       data_sram_addr,
   output logic [31:0]       data_sram_wdata,
   input  logic [31:0]       data_sram_rdata
);

   if (SRAM_LAT < SRAM_LAT_MIN || SRAM_LAT > SRAM_LAT_MAX) begin : g_bad_lat
      $error("lsu_mem_stage: SRAM_LAT out of range");
   end

   lsu_state_e        state_q, state_d;
   lsu_op_e           op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [4:0]        dest_q, dest_d;
   logic [31:0]       data_q, data_d;
   logic              ale_q, ale_d;
   logic [1:0]        cnt_q, cnt_d;

   logic              ale_w;
   logic              access_w;
   logic [3:0]        we_w;
   logic [31:0]       st_wdata_w;
   logic [31:0]       ld_data_w;

`ifdef LSU_ALIGN_CHECK_EN
   assign ale_w = misaligned(lsu_op_e'(req_op), req_addr[1:0]);
`else
   assign ale_w = 1'b0;
`endif

   lsu_lane_align u_align (
      .op_i       (op_q),
      .off_i      (addr_q[1:0]),
      .st_data_i  (wdata_q),
      .rdata_i    (data_sram_rdata),
      .we_o       (we_w),
      .st_wdata_o (st_wdata_w),
      .ld_data_o  (ld_data_w)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_LD_W;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         dest_q  <= 5'd0;
         data_q  <= 32'h0;
         ale_q   <= 1'b0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dest_q  <= dest_d;
         data_q  <= data_d;
         ale_q   <= ale_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dest_d  = dest_q;
      data_d  = data_q;
      ale_d   = ale_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = lsu_op_e'(req_op);
               addr_d  = req_addr;
               wdata_d = req_wdata;
               dest_d  = req_dest;
               data_d  = 32'h0;
               ale_d   = ale_w;
               state_d = ale_w ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            cnt_d   = 2'd0;
            state_d = is_store(op_q) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            // rdata is valid in the SRAM_LAT-th cycle after the strobe
            if (cnt_q == 2'(SRAM_LAT - 1)) begin
               data_d  = ld_data_w;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign access_w        = (state_q == S_ACCESS);
   assign req_ready       = (state_q == S_IDLE);
   assign resp_valid      = (state_q == S_RESP);
   assign resp_we         = resp_valid && !is_store(op_q) && !ale_q;
   assign resp_ale        = resp_valid && ale_q;
   assign resp_dest       = dest_q;
   assign resp_data       = data_q;
   assign data_sram_en    = access_w;
   assign data_sram_we    = access_w ? we_w : 4'b0000;
   assign data_sram_addr  = access_w ? 32'({addr_q[ADDR_W-1:2], 2'b00}) : 32'h0;
   assign data_sram_wdata = access_w ? st_wdata_w : 32'h0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with SRAM_LAT=3 and a small latency-accurate
// SRAM model; expected values are hand-computed constants.
module tb_lsu_mem_stage;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_dest;
   logic        resp_valid, resp_ready, resp_we, resp_ale;
   logic [4:0]  resp_dest;
   logic [31:0] resp_data;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsu_mem_stage #(.SRAM_LAT(LAT), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_dest(req_dest),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
      .resp_dest(resp_dest), .resp_data(resp_data), .resp_ale(resp_ale),
      .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata)
   );

   // SRAM model: 16 words, read data appears LAT cycles after the strobe
   logic [31:0] mem [16];
   logic [31:0] rpipe [LAT];
   int          en_cnt = 0;
   logic [3:0]  cap_we;
   logic [31:0] cap_wdata, cap_addr;

   assign data_sram_rdata = rpipe[LAT-1];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'hCAFEF00D;
      end else if (data_sram_en) begin
         for (int b = 0; b < 4; b++)
            if (data_sram_we[b]) mem[data_sram_addr[5:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
      if (data_sram_en) begin
         en_cnt    <= en_cnt + 1;
         cap_we    <= data_sram_we;
         cap_wdata <= data_sram_wdata;
         cap_addr  <= data_sram_addr;
      end
      rpipe[0] <= data_sram_en ? mem[data_sram_addr[5:2]] : 32'hX;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one op and returns once resp_valid is seen (or the bound expires).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] d, output int lat, output int pulses);
      int e0;
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_dest = d;
      e0 = en_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      pulses = en_cnt - e0;
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("resp_drop", 32'(resp_valid), 32'd0);
      chk("ready_back", 32'(req_ready), 32'd1);
   endtask

   task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] exp);
      int lat, p;
      run_op(op, a, 32'h0, 5'd7, lat, p);
      chk({tag, "_data"}, resp_data, exp);
      chk({tag, "_lat"}, 32'(lat), 32'(2 + LAT));
      chk({tag, "_we"}, 32'(resp_we), 32'd1);
      consume();
   endtask

   initial begin
      int lat, p, e0;
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
      req_wdata = 32'h0; req_dest = 5'd0; resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_we", 32'(resp_we), 32'd0);
      chk("rst_resp_ale", 32'(resp_ale), 32'd0);
      chk("rst_resp_data", resp_data, 32'h0);
      chk("rst_resp_dest", 32'(resp_dest), 32'd0);
      chk("rst_en", 32'(data_sram_en), 32'd0);
      chk("rst_we", 32'(data_sram_we), 32'd0);
      chk("rst_addr", data_sram_addr, 32'h0);
      chk("rst_wdata", data_sram_wdata, 32'h0);
      @(negedge clk); reset = 1'b0;

      // st_w
      run_op(3'd5, 32'h1C000104, 32'hDEADBEEF, 5'd3, lat, p);
      chk("stw_lat", 32'(lat), 32'd2);
      chk("stw_pulses", 32'(p), 32'd1);
      chk("stw_we", 32'(cap_we), 32'hF);
      chk("stw_wdata", cap_wdata, 32'hDEADBEEF);
      chk("stw_addr", cap_addr, 32'h1C000104);
      chk("stw_resp_we", 32'(resp_we), 32'd0);
      chk("stw_resp_data", resp_data, 32'h0);
      chk("stw_dest", 32'(resp_dest), 32'd3);
      consume();

      // st_b into top byte, then read the word back
      run_op(3'd7, 32'h1C000107, 32'h000000A5, 5'd0, lat, p);
      chk("stb_we", 32'(cap_we), 32'h8);
      chk("stb_wdata", cap_wdata, 32'hA5A5A5A5);
      consume();
      run_op(3'd0, 32'h1C000104, 32'h0, 5'd5, lat, p);
      chk("ldw_data", resp_data, 32'hA5ADBEEF);
      chk("ldw_lat", 32'(lat), 32'(2 + LAT));
      chk("ldw_sram_we", 32'(cap_we), 32'h0);
      chk("ldw_dest", 32'(resp_dest), 32'd5);
      chk("ldw_resp_we", 32'(resp_we), 32'd1);
      consume();

      // extraction / extension from 0x80FF7F01
      run_op(3'd5, 32'h1C000108, 32'h80FF7F01, 5'd0, lat, p);
      consume();
      load_chk("ldb_o1", 3'd3, 32'h1C000109, 32'h0000007F);
      load_chk("ldb_o2", 3'd3, 32'h1C00010A, 32'hFFFFFFFF);
      load_chk("ldbu_o3", 3'd4, 32'h1C00010B, 32'h00000080);
      load_chk("ldbu_o0", 3'd4, 32'h1C000108, 32'h00000001);
      load_chk("ldh_o2", 3'd1, 32'h1C00010A, 32'hFFFF80FF);
      load_chk("ldh_o0", 3'd1, 32'h1C000108, 32'h00007F01);
      load_chk("ldhu_o2", 3'd2, 32'h1C00010A, 32'h000080FF);

      // st_h upper half
      run_op(3'd6, 32'h1C00010E, 32'h00001234, 5'd0, lat, p);
      chk("sth_we", 32'(cap_we), 32'hC);
      chk("sth_wdata", cap_wdata, 32'h12341234);
      consume();
      load_chk("sth_rb", 3'd0, 32'h1C00010C, 32'h12340000);

      // backpressure on a load
      resp_ready = 1'b0;
      run_op(3'd2, 32'h1C000108, 32'h0, 5'd9, lat, p);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_data", resp_data, 32'h00007F01);
         chk("bp_dest", 32'(resp_dest), 32'd9);
         chk("bp_we", 32'(resp_we), 32'd1);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      consume();

      // misaligned word load
      run_op(3'd0, 32'h1C000102, 32'h0, 5'd4, lat, p);
`ifdef LSU_ALIGN_CHECK_EN
      chk("ale_lat", 32'(lat), 32'd1);
      chk("ale_pulses", 32'(p), 32'd0);
      chk("ale_flag", 32'(resp_ale), 32'd1);
      chk("ale_we", 32'(resp_we), 32'd0);
      chk("ale_data", resp_data, 32'h0);
`else
      chk("noale_lat", 32'(lat), 32'(2 + LAT));
      chk("noale_pulses", 32'(p), 32'd1);
      chk("noale_addr", cap_addr, 32'h1C000100);
      chk("noale_flag", 32'(resp_ale), 32'd0);
      chk("noale_data", resp_data, 32'hCAFEF00D);
`endif
      consume();

      // reset while in WAIT
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h1C000104; req_dest = 5'd2;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rw_in_wait", 32'(resp_valid | req_ready | data_sram_en), 32'd0);
      reset = 1'b1;
      e0 = en_cnt;
      @(posedge clk); #1;
      chk("rw_valid", 32'(resp_valid), 32'd0);
      chk("rw_ready", 32'(req_ready), 32'd1);
      @(negedge clk); reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("rw_no_en", 32'(en_cnt - e0), 32'd0);
      chk("rw_idle", 32'(req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit for the multi-cycle LoongArch core. It sits directly downstream of EXE and upstream of WB. It accepts one memory operation per request: computed address, store data, op type and destination register. It drives the data SRAM with byte enables, waits the configured SRAM read latency, then extracts and extends load data. The result is returned to WB over a valid/ready handshake.

Parameters:
SRAM_LAT, 1, data SRAM read latency in cycles (1..4); rdata is valid SRAM_LAT cycles after the enable cycle.
ADDR_W, 32, address width.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  1  EXE presents a memory op
req_ready  output  1  LSU can accept; high only in IDLE
req_op  input  3  0 ld_w, 1 ld_h, 2 ld_hu, 3 ld_b, 4 ld_bu, 5 st_w, 6 st_h, 7 st_b
req_addr  input  ADDR_W  effective address (alu_result)
req_wdata  input  32  store data (rkd_value)
req_dest  input  5  load destination register
resp_valid  output  1  result available to WB
resp_ready  input  1  WB consumes result
resp_we  output  1  register write required (loads only, no ALE)
resp_dest  output  5  destination register
resp_data  output  32  extended load data; 0 for stores
resp_ale  output  1  address-alignment error (see Optional Feature)
data_sram_en  output  1  SRAM access strobe, one cycle per op
data_sram_we  output  4  byte write enables
data_sram_addr  output  32  word-aligned SRAM address
data_sram_wdata  output  32  lane-replicated store data
data_sram_rdata  input  32  SRAM read data

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_we=0, resp_ale=0, resp_data=0, resp_dest=0; data_sram_en=0, data_sram_we=0, addr=0, wdata=0. Reset mid-operation abandons the op; no SRAM strobe is issued after reset.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: on req_valid&&req_ready, register op, addr, wdata and dest. Go to ACCESS, or to RESP directly on ALE.
- ACCESS: data_sram_en=1 for exactly this cycle. addr={addr[31:2],2'b00}.
  - Stores: we=4'b1111 for st_w; 4'b0011<<addr[1] *2 lanes for st_h (i.e. 0011 or 1100); 4'b0001<<addr[1:0] for st_b. wdata is replicated: {4{b}}, {2{h}}, or w.
  - Loads: we=0.
  - Next state: stores go to RESP; loads go to WAIT.
- WAIT: a counter runs SRAM_LAT-1 cycles, then samples rdata. With SRAM_LAT=1 the sample happens in the first WAIT cycle. On sample, go to RESP.
- Load extraction: select the byte by addr[1:0] and the halfword by addr[1]. Sign-extend for ld_b and ld_h; zero-extend for ld_bu and ld_hu.
- RESP: resp_valid=1. All resp_* outputs stay stable until resp_ready. When resp_valid&&resp_ready, return to IDLE. req_ready rises the following cycle; no same-cycle back-to-back.
- Latency, req accept to resp_valid: stores 2 cycles; loads 2+SRAM_LAT cycles.
- resp_we=1 only for a load without ALE. A dest of 0 is passed through unchanged; the regfile ignores r0.
- req_valid while not ready is ignored; EXE must hold the request.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined: ALE is raised when a word op has addr[1:0]!=0, or a halfword op has addr[0]!=0.
  - On ALE the LSU goes IDLE->RESP with no SRAM strobe.
  - Response: resp_ale=1, resp_we=0, resp_data=0.
- Undefined: resp_ale is tied 0. The low address bits below access size are ignored: word ops use addr[1:0]=0, halfword ops use addr[0]=0.

Decomposition:
- Package lsu_pkg: op encoding constants, state encoding, the SRAM_LAT legal range.
- One sub-module, lsu_lane_align: combinational store byte-enable and replication, plus load extraction and extension. It is instantiated once.

Test Plan:
- st_w addr 0x1C000104 data 0xDEADBEEF, resp_ready=1 -> en=1, we=1111, wdata=DEADBEEF one cycle; resp_valid 2 cycles after accept with resp_we=0.
- st_b addr ...0x107 data 0x000000A5 -> we=1000, wdata=A5A5A5A5; then ld_w same word -> resp_data=A5xxxxxx with only the top byte changed.
- SRAM word 0x80FF7F01: ld_b at offset 1 -> 0x0000007F; ld_b at offset 2 -> 0xFFFFFFFF; ld_bu at offset 3 -> 0x00000080; ld_h at offset 2 -> 0xFFFF80FF; ld_hu at offset 2 -> 0x000080FF.
- Backpressure: resp_ready held 0 for 5 cycles after a load -> resp_* stable, req_ready=0 throughout; accept completes on the first ready cycle.
- LSU_ALIGN_CHECK_EN: ld_w addr 0x...102 -> no en pulse, resp_ale=1, resp_we=0 one cycle after accept. Without the macro -> word at 0x...100 is read.
- Reset asserted in WAIT with SRAM_LAT=3 -> the next cycle shows IDLE, resp_valid=0, req_ready=1, and no further en pulses.
